pll_lock_mon: RTL and testbench

- Synthesisable multi-channel PLL lock supervisor.
- Supersedes the ad-hoc lock-pulse checking done in PLL benches and is usable on silicon next to HDMI_PLL and the other PLL instances.
- Per channel, it does four things:
  - synchronises the asynchronous pll_lock;
  - debounces it;
  - times lock acquisition against a timeout;
  - counts unexpected lock losses.
- Provides an arm handshake so intentional dynamic reconfiguration (odiv/duty changes) is not flagged as an error.

---
 rtl/pll_lock_mon_pkg.sv | 23 ++
 rtl/pll_lock_mon_ch.sv | 139 +++++++++++++
 rtl/pll_lock_mon.sv | 66 ++++++
 tb/tb_pll_lock_mon.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_lock_mon_pkg.sv
// Shared types, defaults and helpers for the multi-channel PLL lock supervisor.
// Package name is pll_mon_pkg; imported by pll_lock_mon and pll_lock_mon_ch.
package pll_mon_pkg;

    typedef enum logic [1:0] {
        ACQ    = 2'd0,
        LOCKED = 2'd1,
        FAIL   = 2'd2
    } pll_state_e;

    localparam int unsigned DEF_NUM_CH        = 2;
    localparam int unsigned DEF_SYNC_STAGES   = 3;
    localparam int unsigned DEF_STABLE_CYCLES = 16;
    localparam int unsigned DEF_TMR_W         = 20;
    localparam int unsigned DEF_LOCK_TIMEOUT  = 500000;
    localparam int unsigned DEF_CNT_W         = 8;

    // Increment that sticks at max; callers cast the result back to their width.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max);
        return (val >= max) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/pll_lock_mon_ch.sv
// One supervised PLL: synchroniser, debounce, acquisition timer, FSM, loss counter.
// Acquisition-time capture exists only when PLL_MON_ACQ_TIME_EN is defined.
module pll_lock_mon_ch
    import pll_mon_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned TMR_W         = DEF_TMR_W,
    parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int unsigned CNT_W         = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_pll_lock,
    input  logic             i_arm,
    input  logic             i_clr_err,
    output logic             o_ch_locked,
    output logic             o_err_loss,
    output logic             o_err_timeout,
    output logic [CNT_W-1:0] o_loss_cnt,
    output logic [TMR_W-1:0] o_acq_time
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [TMR_W-1:0]       r_stable;
    logic [TMR_W-1:0]       r_tmr;
    pll_state_e             r_state;
    logic                   r_locked;
    logic                   r_err_loss;
    logic                   r_err_to;
    logic [CNT_W-1:0]       r_loss_cnt;

    logic                   w_lock_s;
    logic [TMR_W-1:0]       w_stable_nxt;
    logic [TMR_W-1:0]       w_tmr_nxt;
    pll_state_e             w_state_nxt;
    logic                   w_loss_evt;
    logic                   w_to_evt;
    logic [CNT_W-1:0]       w_loss_cnt_nxt;

    assign w_lock_s = r_sync[SYNC_STAGES-1];

    // Next-state logic; arm overrides every other transition.
    always_comb begin
        w_state_nxt  = r_state;
        w_tmr_nxt    = r_tmr;
        w_loss_evt   = 1'b0;
        w_to_evt     = 1'b0;
        w_stable_nxt = '0;

        if (w_lock_s && !i_arm) begin
            w_stable_nxt = TMR_W'(sat_inc(32'(r_stable), 32'(STABLE_CYCLES)));
        end

        if (i_arm) begin
            w_state_nxt = ACQ;
            w_tmr_nxt   = '0;
        end else begin
            case (r_state)
                ACQ: begin
                    if (r_stable == TMR_W'(STABLE_CYCLES)) begin
                        w_state_nxt = LOCKED;
                    end else if (r_tmr == TMR_W'(LOCK_TIMEOUT - 1)) begin
                        w_state_nxt = FAIL;
                        w_to_evt    = 1'b1;
                    end else begin
                        w_tmr_nxt = r_tmr + TMR_W'(1);
                    end
                end
                LOCKED: begin
                    if (!w_lock_s) begin
                        w_state_nxt = ACQ;
                        w_tmr_nxt   = '0;
                        w_loss_evt  = 1'b1;
                    end
                end
                FAIL:    w_state_nxt = FAIL;
                default: w_state_nxt = ACQ;
            endcase
        end

        // A loss seen in the same cycle as clr_err survives the clear.
        if (i_clr_err) begin
            w_loss_cnt_nxt = w_loss_evt ? CNT_W'(1) : '0;
        end else if (w_loss_evt) begin
            w_loss_cnt_nxt = CNT_W'(sat_inc(32'(r_loss_cnt), (32'd1 << CNT_W) - 32'd1));
        end else begin
            w_loss_cnt_nxt = r_loss_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync     <= '0;
            r_stable   <= '0;
            r_tmr      <= '0;
            r_state    <= ACQ;
            r_locked   <= 1'b0;
            r_err_loss <= 1'b0;
            r_err_to   <= 1'b0;
            r_loss_cnt <= '0;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], i_pll_lock};
            r_stable   <= w_stable_nxt;
            r_tmr      <= w_tmr_nxt;
            r_state    <= w_state_nxt;
            r_locked   <= (w_state_nxt == LOCKED);
            r_err_loss <= w_loss_evt | (r_err_loss & ~i_clr_err);
            r_err_to   <= w_to_evt | (r_err_to & ~i_clr_err);
            r_loss_cnt <= w_loss_cnt_nxt;
        end
    end

`ifdef PLL_MON_ACQ_TIME_EN
    logic             w_capture;
    logic [TMR_W-1:0] r_acq_time;

    // LOCKED can only be entered from ACQ, so this marks each new lock.
    assign w_capture = (r_state == ACQ) && (w_state_nxt == LOCKED);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acq_time <= '0;
        end else if (w_capture) begin
            r_acq_time <= r_tmr;
        end
    end

    assign o_acq_time = r_acq_time;
`else
    assign o_acq_time = '0;
`endif

    assign o_ch_locked   = r_locked;
    assign o_err_loss    = r_err_loss;
    assign o_err_timeout = r_err_to;
    assign o_loss_cnt    = r_loss_cnt;

endmodule

// File: rtl/pll_lock_mon.sv
// Multi-channel PLL lock supervisor: NUM_CH channel monitors plus registered summaries.
// Define PLL_MON_ACQ_TIME_EN to keep per-channel acquisition-time capture.
module pll_lock_mon
    import pll_mon_pkg::*;
#(
    parameter int unsigned NUM_CH        = DEF_NUM_CH,
    parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned TMR_W         = DEF_TMR_W,
    parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int unsigned CNT_W         = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       pll_lock,
    input  logic [NUM_CH-1:0]       arm,
    input  logic                    clr_err,
    output logic [NUM_CH-1:0]       ch_locked,
    output logic                    all_locked,
    output logic [NUM_CH-1:0]       err_loss,
    output logic [NUM_CH-1:0]       err_timeout,
    output logic                    err_any,
    output logic [NUM_CH*CNT_W-1:0] loss_cnt,
    output logic [NUM_CH*TMR_W-1:0] acq_time
);

    logic r_all_locked;
    logic r_err_any;

    genvar g;
    for (g = 0; g < NUM_CH; g++) begin : g_ch
        pll_lock_mon_ch #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_CYCLES(STABLE_CYCLES),
            .TMR_W        (TMR_W),
            .LOCK_TIMEOUT (LOCK_TIMEOUT),
            .CNT_W        (CNT_W)
        ) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .i_pll_lock   (pll_lock[g]),
            .i_arm        (arm[g]),
            .i_clr_err    (clr_err),
            .o_ch_locked  (ch_locked[g]),
            .o_err_loss   (err_loss[g]),
            .o_err_timeout(err_timeout[g]),
            .o_loss_cnt   (loss_cnt[g*CNT_W +: CNT_W]),
            .o_acq_time   (acq_time[g*TMR_W +: TMR_W])
        );
    end

    // Summaries deliberately lag the per-channel flags by one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_all_locked <= 1'b0;
            r_err_any    <= 1'b0;
        end else begin
            r_all_locked <= &ch_locked;
            r_err_any    <= |{err_loss, err_timeout};
        end
    end

    assign all_locked = r_all_locked;
    assign err_any    = r_err_any;

endmodule

// File: tb/tb_pll_lock_mon.sv
// Directed + randomized bench for pll_lock_mon against a cycle-level behavioural model.
// Honours PLL_MON_ACQ_TIME_EN for the expected acq_time values.
module tb_pll_lock_mon;

    localparam int NUM_CH  = 2;
    localparam int SYNC    = 3;
    localparam int STABLE  = 4;
    localparam int TMR_W   = 8;
    localparam int TIMEOUT = 100;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef PLL_MON_ACQ_TIME_EN
    localparam bit ACQ_EN = 1'b1;
`else
    localparam bit ACQ_EN = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NUM_CH-1:0]       pll_lock;
    logic [NUM_CH-1:0]       arm;
    logic                    clr_err;
    logic [NUM_CH-1:0]       ch_locked;
    logic                    all_locked;
    logic [NUM_CH-1:0]       err_loss;
    logic [NUM_CH-1:0]       err_timeout;
    logic                    err_any;
    logic [NUM_CH*CNT_W-1:0] loss_cnt;
    logic [NUM_CH*TMR_W-1:0] acq_time;

    pll_lock_mon #(
        .NUM_CH       (NUM_CH),
        .SYNC_STAGES  (SYNC),
        .STABLE_CYCLES(STABLE),
        .TMR_W        (TMR_W),
        .LOCK_TIMEOUT (TIMEOUT),
        .CNT_W        (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_lock   (pll_lock),
        .arm        (arm),
        .clr_err    (clr_err),
        .ch_locked  (ch_locked),
        .all_locked (all_locked),
        .err_loss   (err_loss),
        .err_timeout(err_timeout),
        .err_any    (err_any),
        .loss_cnt   (loss_cnt),
        .acq_time   (acq_time)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model state: sample history, run length of high samples, cycles waited, mode flags.
    logic [NUM_CH-1:0] samp[$];
    int last_rst = -1;
    int m_run[NUM_CH];
    int m_wait[NUM_CH];
    int m_cnt[NUM_CH];
    int m_acq[NUM_CH];
    bit m_lk[NUM_CH];
    bit m_fail[NUM_CH];
    bit m_el[NUM_CH];
    bit m_et[NUM_CH];
    bit m_all;
    bit m_any;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_edge();
        logic [NUM_CH-1:0] ls;
        ls = '0;
        if (cyc >= SYNC && cyc - SYNC > last_rst) ls = samp[cyc - SYNC];
        samp.push_back(pll_lock);
        if (!rst_n) begin
            last_rst = cyc;
            m_all = 1'b0;
            m_any = 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                m_run[c] = 0; m_wait[c] = 0; m_cnt[c] = 0; m_acq[c] = 0;
                m_lk[c] = 1'b0; m_fail[c] = 1'b0; m_el[c] = 1'b0; m_et[c] = 1'b0;
            end
            return;
        end
        m_all = 1'b1;
        m_any = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            m_all = m_all & m_lk[c];
            m_any = m_any | m_el[c] | m_et[c];
        end
        for (int c = 0; c < NUM_CH; c++) begin
            bit loss;
            bit tout;
            loss = 1'b0;
            tout = 1'b0;
            if (arm[c]) begin
                m_lk[c] = 1'b0; m_fail[c] = 1'b0; m_wait[c] = 0;
            end else if (m_lk[c]) begin
                if (!ls[c]) begin
                    m_lk[c] = 1'b0; m_wait[c] = 0; loss = 1'b1;
                end
            end else if (!m_fail[c]) begin
                if (m_run[c] == STABLE) begin
                    m_lk[c] = 1'b1; m_acq[c] = m_wait[c];
                end else if (m_wait[c] == TIMEOUT - 1) begin
                    m_fail[c] = 1'b1; tout = 1'b1;
                end else begin
                    m_wait[c]++;
                end
            end
            m_run[c] = (ls[c] && !arm[c]) ? ((m_run[c] < STABLE) ? m_run[c] + 1 : STABLE) : 0;
            m_el[c]  = loss || (m_el[c] && !clr_err);
            m_et[c]  = tout || (m_et[c] && !clr_err);
            if (clr_err)                       m_cnt[c] = loss ? 1 : 0;
            else if (loss && m_cnt[c] < CNT_MAX) m_cnt[c]++;
        end
    endtask

    task automatic compare_all();
        logic [NUM_CH-1:0]       e_lk;
        logic [NUM_CH-1:0]       e_el;
        logic [NUM_CH-1:0]       e_et;
        logic [NUM_CH*CNT_W-1:0] e_cnt;
        logic [NUM_CH*TMR_W-1:0] e_acq;
        for (int c = 0; c < NUM_CH; c++) begin
            e_lk[c] = m_lk[c];
            e_el[c] = m_el[c];
            e_et[c] = m_et[c];
            e_cnt[c*CNT_W +: CNT_W] = CNT_W'(m_cnt[c]);
            e_acq[c*TMR_W +: TMR_W] = ACQ_EN ? TMR_W'(m_acq[c]) : '0;
        end
        check("m_ch_locked", 64'(ch_locked), 64'(e_lk));
        check("m_all_locked", 64'(all_locked), 64'(m_all));
        check("m_err_loss", 64'(err_loss), 64'(e_el));
        check("m_err_timeout", 64'(err_timeout), 64'(e_et));
        check("m_err_any", 64'(err_any), 64'(m_any));
        check("m_loss_cnt", 64'(loss_cnt), 64'(e_cnt));
        check("m_acq_time", 64'(acq_time), 64'(e_acq));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        compare_all();
    endtask

    initial begin
        rst_n = 1'b0; pll_lock = '0; arm = '0; clr_err = 1'b0;
        repeat (4) tick();
        check("rst_ch_locked", 64'(ch_locked), 0);
        check("rst_err_any", 64'(err_any), 0);
        check("rst_loss_cnt", 64'(loss_cnt), 0);

        // Basic lock on channel 0, raised at cycle 10
        rst_n = 1'b1;
        repeat (6) tick();
        pll_lock[0] = 1'b1;
        repeat (7) tick();
        check("lock_lat_early", 64'(ch_locked[0]), 0);
        tick();
        check("lock_lat", 64'(ch_locked[0]), 1);
        check("acq_time_basic", 64'(acq_time[TMR_W-1:0]), ACQ_EN ? 64'd13 : 64'd0);
        check("lock_no_err", 64'(err_any), 0);

        // Channel 1 never locks: timeout at tmr=99
        while (cyc < 103) tick();
        check("tout_early", 64'(err_timeout[1]), 0);
        tick();
        check("tout", 64'(err_timeout[1]), 1);
        check("err_any_lag0", 64'(err_any), 0);
        tick();
        check("err_any_lag1", 64'(err_any), 1);
        pll_lock[1] = 1'b1;
        repeat (20) tick();
        check("fail_sticky", 64'(ch_locked[1]), 0);

        // Reconfig on channel 0 with a 3-cycle glitch inside the 40 low cycles
        pll_lock[0] = 1'b0; arm[0] = 1'b1;
        tick();
        arm[0] = 1'b0;
        repeat (9) tick();
        pll_lock[0] = 1'b1;
        repeat (3) tick();
        pll_lock[0] = 1'b0;
        repeat (27) tick();
        check("glitch_no_lock", 64'(ch_locked[0]), 0);
        check("glitch_no_loss", 64'(err_loss[0]), 0);
        pll_lock[0] = 1'b1;
        repeat (8) tick();
        check("reconf_relock", 64'(ch_locked[0]), 1);
        check("reconf_acq", 64'(acq_time[TMR_W-1:0]), ACQ_EN ? 64'd46 : 64'd0);
        check("reconf_no_loss", 64'(err_loss[0]), 0);

        // Four losses: counter reads 1, 2, 3, 3
        for (int k = 0; k < 4; k++) begin
            pll_lock[0] = 1'b0;
            repeat (3) tick();
            check("loss_pre", 64'(err_loss[0]), 64'(k > 0));
            tick();
            check("loss_flag", 64'(err_loss[0]), 1);
            check("loss_cnt", 64'(loss_cnt[CNT_W-1:0]), 64'((k + 1 > CNT_MAX) ? CNT_MAX : k + 1));
            check("loss_unlock", 64'(ch_locked[0]), 0);
            pll_lock[0] = 1'b1;
            repeat (10) tick();
            check("loss_relock", 64'(ch_locked[0]), 1);
        end

        // clr_err in the same cycle as a loss event
        pll_lock[0] = 1'b0;
        repeat (3) tick();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("clr_race_flag", 64'(err_loss[0]), 1);
        check("clr_race_cnt", 64'(loss_cnt[CNT_W-1:0]), 1);
        check("clr_tout", 64'(err_timeout[1]), 0);
        pll_lock[0] = 1'b1;

        // arm on channel 1 in the exact timeout cycle
        pll_lock[1] = 1'b0; arm[1] = 1'b1;
        tick();
        arm[1] = 1'b0;
        repeat (99) tick();
        arm[1] = 1'b1;
        tick();
        arm[1] = 1'b0;
        check("arm_tout_race", 64'(err_timeout[1]), 0);
        repeat (99) tick();
        check("rearm_tout_early", 64'(err_timeout[1]), 0);
        tick();
        check("rearm_tout", 64'(err_timeout[1]), 1);

        // Lock both channels
        pll_lock[1] = 1'b1; arm[1] = 1'b1;
        tick();
        arm[1] = 1'b0;
        repeat (7) tick();
        check("both_locked", 64'(ch_locked), 64'h3);
        tick();
        check("all_locked", 64'(all_locked), 1);

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(19) == 0) pll_lock[c] = ~pll_lock[c];
                arm[c] = ($urandom_range(63) == 0);
            end
            clr_err = ($urandom_range(99) == 0);
            tick();
        end
        arm = '0; clr_err = 1'b0;

        // Reset mid-operation
        rst_n = 1'b0;
        tick();
        check("midrst_locked", 64'(ch_locked), 0);
        check("midrst_all", 64'(all_locked), 0);
        check("midrst_err_any", 64'(err_any), 0);
        check("midrst_cnt", 64'(loss_cnt), 0);
        check("midrst_acq", 64'(acq_time), 0);
        rst_n = 1'b1;
        repeat (5) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
